// File: rtl/mem_data_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pkg
//  Purpose  : Shared encodings for the data-side memory arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package mem_pkg;

    localparam logic [1:0] OP_ILLEGAL = 2'd0;
    localparam logic [1:0] OP_RD1     = 2'd1;
    localparam logic [1:0] OP_RD2     = 2'd2;
    localparam logic [1:0] OP_WR      = 2'd3;

    localparam logic [1:0] MRD_NONE = 2'd0;
    localparam logic [1:0] MRD_ONE  = 2'd1;
    localparam logic [1:0] MRD_TWO  = 2'd2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam int unsigned DATA_LIMIT_DEFAULT = 32'd1048576;

    function automatic logic [1:0] mem_read_for(input logic [1:0] op);
        case (op)
            OP_RD1:  return MRD_ONE;
            OP_RD2:  return MRD_TWO;
            default: return MRD_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_data_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_data_arbiter_if
//  Purpose  : Requester handshakes plus the memory data-port bus.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_data_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          r0_valid;
    logic          r0_ready;
    logic [1:0]    r0_op;
    logic [AW-1:0] r0_addr1;
    logic [AW-1:0] r0_addr2;
    logic [DW-1:0] r0_wdata;
    logic          r0_rsp_valid;
    logic [DW-1:0] r0_rsp_data1;
    logic [DW-1:0] r0_rsp_data2;
    logic          r0_rsp_err;

    logic          r1_valid;
    logic          r1_ready;
    logic [1:0]    r1_op;
    logic [AW-1:0] r1_addr1;
    logic [AW-1:0] r1_addr2;
    logic [DW-1:0] r1_wdata;
    logic          r1_rsp_valid;
    logic [DW-1:0] r1_rsp_data1;
    logic [DW-1:0] r1_rsp_data2;
    logic          r1_rsp_err;

    logic          mem_en;
    logic [1:0]    mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr1;
    logic [AW-1:0] mem_addr2;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_data1;
    logic [DW-1:0] mem_data2;

    // slave: the arbiter itself; master: requesters and the memory around it
    modport slave (
        input  r0_valid, r0_op, r0_addr1, r0_addr2, r0_wdata,
        output r0_ready, r0_rsp_valid, r0_rsp_data1, r0_rsp_data2, r0_rsp_err,
        input  r1_valid, r1_op, r1_addr1, r1_addr2, r1_wdata,
        output r1_ready, r1_rsp_valid, r1_rsp_data1, r1_rsp_data2, r1_rsp_err,
        output mem_en, mem_read, mem_write, mem_addr1, mem_addr2, mem_wdata,
        input  mem_data1, mem_data2
    );

    modport master (
        output r0_valid, r0_op, r0_addr1, r0_addr2, r0_wdata,
        input  r0_ready, r0_rsp_valid, r0_rsp_data1, r0_rsp_data2, r0_rsp_err,
        output r1_valid, r1_op, r1_addr1, r1_addr2, r1_wdata,
        input  r1_ready, r1_rsp_valid, r1_rsp_data1, r1_rsp_data2, r1_rsp_err,
        input  mem_en, mem_read, mem_write, mem_addr1, mem_addr2, mem_wdata,
        output mem_data1, mem_data2
    );

endinterface
`default_nettype wire

// File: rtl/mem_data_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-way combinational round-robin pick; history lives in parent.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb2 (
    input  wire logic [1:0] req,
    input  wire logic       last_grant,
    output logic      [1:0] grant,
    output logic            grant_id
);

    always_comb begin
        grant_id = 1'b0;
        if (req == 2'b11) begin
            grant_id = ~last_grant;
        end else if (req[1]) begin
            grant_id = 1'b1;
        end
        grant = 2'b00;
        if (req != 2'b00) begin
            grant = grant_id ? 2'b10 : 2'b01;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_data_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_data_arbiter
//  Purpose  : Round-robin share of the unified memory data port, one
//             transaction per three cycles, with data-region bound checking.
//  Revision : 1.0  initial release
// ============================================================================
module mem_data_arbiter
    import mem_pkg::*;
#(
    parameter int          AW         = 32,
    parameter int          DW         = 32,
    parameter int unsigned DATA_LIMIT = DATA_LIMIT_DEFAULT
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mem_data_arbiter_if.slave  bus
);

    localparam logic [AW-1:0] c_limit = AW'(DATA_LIMIT);

    logic [1:0]    r_state;
    logic          r_last_grant;
    logic          r_id;
    logic [1:0]    r_op;
    logic [AW-1:0] r_addr1;
    logic [AW-1:0] r_addr2;
    logic [DW-1:0] r_wdata;
    logic          r_err;
    logic [1:0]    r_rsp_valid;
    logic [1:0]    r_rsp_err;
    logic [DW-1:0] r_rsp_data1 [2];
    logic [DW-1:0] r_rsp_data2 [2];

    logic [1:0]    w_req;
    logic [1:0]    w_grant;
    logic          w_grant_id;
    logic          w_idle;
    logic          w_issue;
    logic [1:0]    w_sel_op;
    logic [AW-1:0] w_sel_addr1;
    logic [AW-1:0] w_sel_addr2;
    logic [DW-1:0] w_sel_wdata;
    logic          w_sel_err;

    assign w_req = {bus.r1_valid, bus.r0_valid};

    rr_arb2 u_arb (
        .req        (w_req),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .grant_id   (w_grant_id)
    );

    assign w_idle       = (r_state == ST_IDLE);
    assign bus.r0_ready = w_idle & w_grant[0];
    assign bus.r1_ready = w_idle & w_grant[1];

    assign w_sel_op    = w_grant_id ? bus.r1_op    : bus.r0_op;
    assign w_sel_addr1 = w_grant_id ? bus.r1_addr1 : bus.r0_addr1;
    assign w_sel_addr2 = w_grant_id ? bus.r1_addr2 : bus.r0_addr2;
    assign w_sel_wdata = w_grant_id ? bus.r1_wdata : bus.r0_wdata;

    // Any error suppresses the memory strobes, which keeps the instruction region write-safe
    assign w_sel_err = (w_sel_op == OP_ILLEGAL) || (w_sel_addr1 >= c_limit) ||
                       ((w_sel_op == OP_RD2) && (w_sel_addr2 >= c_limit));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_op         <= OP_ILLEGAL;
            r_addr1      <= '0;
            r_addr2      <= '0;
            r_wdata      <= '0;
            r_err        <= 1'b0;
            r_rsp_valid  <= 2'b00;
            r_rsp_err    <= 2'b00;
            r_rsp_data1  <= '{default: '0};
            r_rsp_data2  <= '{default: '0};
        end else begin
            r_rsp_valid <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (w_req != 2'b00) begin
                        r_id         <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_op         <= w_sel_op;
                        r_addr1      <= w_sel_addr1;
                        r_addr2      <= w_sel_addr2;
                        r_wdata      <= w_sel_wdata;
                        r_err        <= w_sel_err;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: r_state <= ST_RESP;
                ST_RESP: begin
                    r_rsp_valid[r_id] <= 1'b1;
                    r_rsp_err[r_id]   <= r_err;
                    r_rsp_data1[r_id] <= (!r_err && (r_op == OP_RD1 || r_op == OP_RD2)) ?
                                         bus.mem_data1 : '0;
                    r_rsp_data2[r_id] <= (!r_err && r_op == OP_RD2) ? bus.mem_data2 : '0;
                    r_state           <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_issue       = (r_state == ST_ISSUE) && !r_err;
    assign bus.mem_en    = 1'b1;
    assign bus.mem_read  = w_issue ? mem_read_for(r_op) : MRD_NONE;
    assign bus.mem_write = w_issue && (r_op == OP_WR);
    assign bus.mem_addr1 = r_addr1;
    assign bus.mem_addr2 = r_addr2;
    assign bus.mem_wdata = r_wdata;

    assign bus.r0_rsp_valid = r_rsp_valid[0];
    assign bus.r0_rsp_err   = r_rsp_err[0];
    assign bus.r0_rsp_data1 = r_rsp_data1[0];
    assign bus.r0_rsp_data2 = r_rsp_data2[0];
    assign bus.r1_rsp_valid = r_rsp_valid[1];
    assign bus.r1_rsp_err   = r_rsp_err[1];
    assign bus.r1_rsp_data1 = r_rsp_data1[1];
    assign bus.r1_rsp_data2 = r_rsp_data2[1];

endmodule
`default_nettype wire

// File: doc/mem_data_arbiter.md
Name: mem_data_arbiter

Overview:
- Shares the unified memory's single data-side port (two read addresses, one write) between two requesters.
  - Requester 0: the core load/store stage.
  - Requester 1: the program loader/DMA.
- Round-robin arbitration, request/ready handshake, fixed-latency response pulse.
- Drives the memory's EN, mem_read, mem_write and address/data inputs. Enforces the data-region bound so that no instruction-region write is ever issued.

Parameters:
- AW, 32, address width
- DW, 32, data width
- DATA_LIMIT, 1048576, first non-data word address (half of memory depth); data accesses require addr < DATA_LIMIT

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rX_valid  in  1  request valid, X in {0,1}
- rX_ready  out  1  request accepted this cycle
- rX_op  in  2  1=read one word, 2=read two words, 3=write, 0=illegal
- rX_addr1  in  AW  first address / write address
- rX_addr2  in  AW  second address (op 2 only)
- rX_wdata  in  DW  write data
- rX_rsp_valid  out  1  one-cycle response pulse
- rX_rsp_data1  out  DW  read data 1
- rX_rsp_data2  out  DW  read data 2
- rX_rsp_err  out  1  range or op error
- mem_en  out  1  memory enable
- mem_read  out  2  memory read mode
- mem_write  out  1  memory write strobe
- mem_addr1  out  AW  memory address 1
- mem_addr2  out  AW  memory address 2
- mem_wdata  out  DW  memory write data
- mem_data1  in  DW  memory registered read data 1
- mem_data2  in  DW  memory registered read data 2

Behaviour:
- Reset values:
  - State IDLE; last_grant=1, so requester 0 wins the first tie.
  - All rX_ready, rX_rsp_valid, rX_rsp_err = 0; rsp data = 0.
  - mem_en=1, mem_read=0, mem_write=0, mem addresses/wdata=0.
- FSM IDLE -> ISSUE -> RESP -> IDLE, one transaction per 3 cycles. No pipelining.
- IDLE, cycle T:
  - If any rX_valid, pick the winner. If only one is valid, it wins; if both, the one != last_grant wins.
  - rX_ready is combinational, asserted for the winner only, and only in IDLE.
  - At the edge ending T: latch op/addr/wdata, requester id and err flag; update last_grant; go to ISSUE.
  - err is set when:
    - op==0, or
    - addr1>=DATA_LIMIT, or
    - (op==2 and addr2>=DATA_LIMIT).
- ISSUE, cycle T+1:
  - If err: mem_read=0, mem_write=0.
  - Else op1: mem_read=1; op2: mem_read=2; op3: mem_write=1 with mem_read=0.
  - mem_addr1/2 and mem_wdata come from the latched values.
  - mem_write and mem_read are never both nonzero.
  - Go to RESP.
- RESP, cycle T+2:
  - mem_read=0, mem_write=0.
  - At the edge ending T+2, capture response data into the winner's rsp registers:
    - err or write: both words = 0.
    - op1: data1=mem_data1, data2=0.
    - op2: both words from memory.
  - Go to IDLE.
- Response, cycle T+3:
  - The winner's rX_rsp_valid=1 for exactly one cycle, with rsp_err equal to the latched err.
  - The loser's rsp_valid stays 0.
  - rsp data registers hold until the next capture for that requester.
  - No response backpressure: the requester must sink the pulse.
- Acceptance and ordering:
  - A new request may be accepted in T+3, since the FSM is already in IDLE.
  - A losing requester keeps valid high; it is granted at the next IDLE when the other is not requesting or last_grant favours it.
- Reset mid-transaction: any state returns to IDLE next cycle; the in-flight response is dropped with no rsp_valid; mem_write is deasserted.
- Address compares are unsigned, at full AW width.

Decomposition:
- Shared package mem_pkg holds:
  - op encoding constants (OP_ILLEGAL=0, OP_RD1=1, OP_RD2=2, OP_WR=3);
  - mem_read encodings;
  - FSM state encoding (IDLE=0, ISSUE=1, RESP=2);
  - DATA_LIMIT default.
- One sub-module, rr_arb2: inputs req[1:0] and last_grant; outputs grant[1:0] one-hot plus grant_id. Purely combinational; last_grant stays in the parent.

Test Plan:
- r0 op3 addr1=0x10 wdata=0xDEADBEEF:
  - r0_ready in T; mem_write=1, mem_addr1=0x10 in T+1.
  - r0_rsp_valid=1, err=0 in T+3.
  - Then r0 op1 addr1=0x10 -> rsp_data1=0xDEADBEEF.
- Both valid in the same cycle after reset, r0 op1 addr 0x10, r1 op3 addr 0x20 wdata 5:
  - r0 is granted first; r1 ready asserts at T+3.
  - Next tie grants r1 (alternation verified over 4 ties).
- r1 op2 addr1=0x10, addr2=0x20, after writes 0xDEADBEEF/5 -> data1=0xDEADBEEF, data2=5, mem_read=2 for exactly one cycle.
- r0 op3 addr1=DATA_LIMIT -> mem_write stays 0 throughout, rsp_err=1, data 0; a later read of address 0 returns its prior value.
- r0 op0, and op2 with addr2=DATA_LIMIT+4 -> rsp_err=1 in T+3, mem_read never nonzero.
- reset asserted in ISSUE of a write -> mem_write low next cycle, no rsp_valid, all outputs at reset values; next request completes normally.
